// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter.
//   owner_t     : owner of an access travelling through the 2-stage SRAM pipe
//   cpu_state_t : CPU bus handshake state
//   VRAM_ADDR_W / VRAM_DATA_W : VRAM geometry (16K x 8)
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W = 14;
  localparam int unsigned VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    NONE,
    VID,
    CRD,
    CWR
  } owner_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_BUSY,
    C_DONE
  } cpu_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port synchronous VRAM between the display
// fetch path (fixed latency, priority) and the Z80 CPU bus (WAIT-stalled,
// served in free slots, with a starvation limit that forces a CPU access
// through after STARVE_LIMIT consecutive lost cycles).
//
// Ports
//   pixel_clock    : single clock for arbiter, VRAM and fetch logic
//   reset          : asynchronous active-low reset
//   vid_req/addr   : one-cycle display fetch request and address
//   vid_data/valid : fetched byte, strobed 3 edges after the sampled request
//   vid_miss       : strobe, fetch dropped in favour of a starved CPU access
//   cpu_req/we/addr/wdata : CPU access (level request, stable while held)
//   cpu_rdata      : last CPU read data, held until the next read completes
//   cpu_wait       : combinational WAIT to the CPU
//   cpu_ack        : strobe, CPU access complete
//   mem_en/we/addr/wdata : registered VRAM command
//   mem_rdata      : VRAM read data, valid the cycle after the address is sampled
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W       = VRAM_ADDR_W,
  parameter int unsigned DATA_W       = VRAM_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_data_valid,
  output logic              vid_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  output logic              cpu_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  cpu_state_t       cpu_state;
  cpu_state_t       cpu_state_next;
  owner_t           grant;
  owner_t           own1;
  owner_t           own2;
  logic [CNT_W-1:0] starve_cnt;
  logic             cpu_pending;
  logic             grant_cpu;
  logic             grant_vid;
  logic             lose;
  logic             ack_evt;
  logic             ack_ok;

  // Grant decode. The CPU only competes once its FSM has reached C_WAIT.
  always_comb begin
    cpu_pending = cpu_req && (cpu_state == C_WAIT);
    grant_cpu   = cpu_pending && (!vid_req || (starve_cnt == LIMIT));
    grant_vid   = vid_req && !grant_cpu;
    lose        = cpu_pending && grant_vid;
    grant       = NONE;
    if (grant_vid) begin
      grant = VID;
    end else if (grant_cpu) begin
      grant = cpu_we ? CWR : CRD;
    end
  end

  // Writes complete when the SRAM samples them (stage 1); reads when the
  // returned data is captured (stage 2). An access whose request was dropped
  // while in flight finishes in the SRAM but is not acknowledged.
  always_comb begin
    ack_evt = (own1 == CWR) || (own2 == CRD);
    ack_ok  = ack_evt && cpu_req && (cpu_state == C_BUSY);
  end

  // VRAM command register; address/data hold when idle.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      vid_miss  <= 1'b0;
    end else begin
      mem_en   <= (grant != NONE);
      mem_we   <= (grant == CWR);
      vid_miss <= vid_req && grant_cpu;
      if (grant_vid) begin
        mem_addr <= vid_addr;
      end else if (grant_cpu) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
    end
  end

  // Owner pipe: stage 1 = SRAM sampling the address, stage 2 = data return.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      own1 <= NONE;
      own2 <= NONE;
    end else begin
      own1 <= grant;
      own2 <= own1;
    end
  end

  // Read data capture and completion strobes.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      vid_data       <= '0;
      vid_data_valid <= 1'b0;
      cpu_rdata      <= '0;
      cpu_ack        <= 1'b0;
    end else begin
      vid_data_valid <= (own2 == VID);
      cpu_ack        <= ack_ok;
      if (own2 == VID) begin
        vid_data <= mem_rdata;
      end
      if ((own2 == CRD) && ack_ok) begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

  // Starvation counter: counts consecutive losses in C_WAIT, clears otherwise.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (lose) begin
      if (starve_cnt != '1) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // CPU FSM: state register.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      cpu_state <= C_IDLE;
    end else begin
      cpu_state <= cpu_state_next;
    end
  end

  // CPU FSM: next state.
  always_comb begin
    cpu_state_next = cpu_state;
    unique case (cpu_state)
      C_IDLE: if (cpu_req) cpu_state_next = C_WAIT;
      C_WAIT: begin
        if (!cpu_req) begin
          cpu_state_next = C_IDLE;
        end else if (grant_cpu) begin
          cpu_state_next = C_BUSY;
        end
      end
      C_BUSY: begin
        if (!cpu_req) begin
          cpu_state_next = C_IDLE;
        end else if (ack_evt) begin
          cpu_state_next = C_DONE;
        end
      end
      C_DONE: if (!cpu_req) cpu_state_next = C_IDLE;
      default: cpu_state_next = C_IDLE;
    endcase
  end

  // CPU FSM: outputs.
  always_comb begin
    cpu_wait = cpu_req && (cpu_state != C_DONE);
  end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_req = 1'b0;
  logic [13:0] vid_addr = '0;
  logic [7:0]  vid_data;
  logic        vid_data_valid;
  logic        vid_miss;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait;
  logic        cpu_ack;
  logic        mem_en;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;
  int miss_cnt = 0;

  logic [7:0] obs_vid[$];
  logic [7:0] obs_ack[$];
  logic [7:0] exp_vid[$];
  logic [7:0] exp_cpu[$];
  logic [7:0] got;
  logic [7:0] want;

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W(14),
    .DATA_W(8),
    .STARVE_LIMIT(4),
    .CNT_W(3)
  ) dut (
    .pixel_clock(clk),
    .reset(rst_n),
    .vid_req(vid_req),
    .vid_addr(vid_addr),
    .vid_data(vid_data),
    .vid_data_valid(vid_data_valid),
    .vid_miss(vid_miss),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_wait(cpu_wait),
    .cpu_ack(cpu_ack),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Initial VRAM contents known to the bench.
  function automatic logic [7:0] exp_mem(input logic [13:0] a);
    if (a == 14'h0123) return 8'h5A;
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hA3;
  endfunction

  // Synchronous single-port SRAM model, loaded once on the first edge.
  logic [7:0] sram [0:16383];
  logic       loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16384; i++) sram[i] <= exp_mem(14'(i));
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  // Output monitor: records strobed results for the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vid_data_valid) obs_vid.push_back(vid_data);
      if (cpu_ack)        obs_ack.push_back(cpu_rdata);
      if (vid_miss)       miss_cnt++;
    end
  end

  initial begin
    #200000;
    $display("watchdog expired: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Full CPU handshake: raise request, wait for ack (bounded), drop request.
  task automatic cpu_cycle(input logic we, input logic [13:0] a, input logic [7:0] d,
                           output int lat, output logic wait_ok);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    lat = -1; wait_ok = 1'b1;
    #1;
    if (cpu_wait !== 1'b1) wait_ok = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (cpu_ack === 1'b1) begin
        lat = i;
        if (cpu_wait !== 1'b0) wait_ok = 1'b0;
        break;
      end else if (cpu_wait !== 1'b1) begin
        wait_ok = 1'b0;
      end
    end
    cpu_req = 1'b0;
    step();
  endtask

  task automatic test_reset;
    int lat;
    logic wok;
    repeat (3) step();
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 24'h0) begin
      errors++; $display("FAIL reset_mem: got %h want 0", {mem_en, mem_we, mem_addr, mem_wdata});
    end
    checks++;
    if ({vid_data, vid_data_valid, vid_miss, cpu_rdata, cpu_ack, cpu_wait} !== 20'h0) begin
      errors++; $display("FAIL reset_out: got %h want 0",
                         {vid_data, vid_data_valid, vid_miss, cpu_rdata, cpu_ack, cpu_wait});
    end
    rst_n = 1'b1;
    step();
    // CPU read caught in C_BUSY by reset
    cpu_we = 1'b0; cpu_addr = 14'h0200; cpu_req = 1'b1;
    step();
    step();
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 14'h0200}) begin
      errors++; $display("FAIL reset_pre_grant: got %h want %h", {mem_en, mem_addr}, {1'b1, 14'h0200});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, vid_data, vid_data_valid, vid_miss, cpu_rdata, cpu_ack} !== 43'h0) begin
      errors++; $display("FAIL reset_mid_read: got %h want 0",
                         {mem_en, mem_we, mem_addr, mem_wdata, vid_data, vid_data_valid, vid_miss, cpu_rdata, cpu_ack});
    end
    cpu_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
    checks++;
    if (obs_ack.size() != 0) begin
      errors++; $display("FAIL reset_no_ack: got %0d acks want 0", obs_ack.size());
    end
    obs_ack.delete();
    exp_cpu.push_back(exp_mem(14'h0200));
    cpu_cycle(1'b0, 14'h0200, 8'h00, lat, wok);
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL reset_reread_lat: got %0d want 4", lat);
    end
    checks++;
    if (obs_ack.size() == 0 || exp_cpu.size() == 0) begin
      errors++; $display("FAIL reset_reread_data: got %0d entries want 1", obs_ack.size());
    end else begin
      got = obs_ack.pop_front(); want = exp_cpu.pop_front();
      if (got !== want) begin
        errors++; $display("FAIL reset_reread_data: got %h want %h", got, want);
      end
    end
  endtask

  task automatic test_vid_fetch;
    vid_addr = 14'h0123; vid_req = 1'b1;
    exp_vid.push_back(8'h5A);
    step();
    vid_req = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_addr, vid_data_valid} !== {1'b1, 1'b0, 14'h0123, 1'b0}) begin
      errors++; $display("FAIL vid_e0: got %h want %h", {mem_en, mem_we, mem_addr, vid_data_valid},
                         {1'b1, 1'b0, 14'h0123, 1'b0});
    end
    step();
    checks++;
    if ({mem_en, vid_data_valid} !== 2'b00) begin
      errors++; $display("FAIL vid_e1: got %b want 00", {mem_en, vid_data_valid});
    end
    step();
    checks++;
    if ({vid_data_valid, vid_data} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL vid_e2: got %h want %h", {vid_data_valid, vid_data}, {1'b1, 8'h5A});
    end
    step();
    checks++;
    if (obs_vid.size() == 0 || exp_vid.size() == 0) begin
      errors++; $display("FAIL vid_sb: got %0d entries want 1", obs_vid.size());
    end else begin
      got = obs_vid.pop_front(); want = exp_vid.pop_front();
      if (got !== want) begin
        errors++; $display("FAIL vid_sb: got %h want %h", got, want);
      end
    end
  endtask

  task automatic test_cpu_write_read;
    int lat;
    logic wok;
    cpu_cycle(1'b1, 14'h2000, 8'hA5, lat, wok);
    checks++;
    if (lat != 3 || wok !== 1'b1) begin
      errors++; $display("FAIL cpu_write: got lat %0d wait_ok %b want 3 1", lat, wok);
    end
    checks++;
    if (sram[14'h2000] !== 8'hA5 || obs_ack.size() != 1) begin
      errors++; $display("FAIL cpu_write_mem: got %h acks %0d want a5 acks 1", sram[14'h2000], obs_ack.size());
    end
    obs_ack.delete();
    exp_cpu.push_back(8'hA5);
    cpu_cycle(1'b0, 14'h2000, 8'h00, lat, wok);
    checks++;
    if (lat != 4 || wok !== 1'b1) begin
      errors++; $display("FAIL cpu_read: got lat %0d wait_ok %b want 4 1", lat, wok);
    end
    checks++;
    if (obs_ack.size() == 0 || exp_cpu.size() == 0) begin
      errors++; $display("FAIL cpu_read_data: got %0d entries want 1", obs_ack.size());
    end else begin
      got = obs_ack.pop_front(); want = exp_cpu.pop_front();
      if (got !== want) begin
        errors++; $display("FAIL cpu_read_data: got %h want %h", got, want);
      end
    end
  endtask

  task automatic test_contention;
    int miss0;
    int lat;
    miss0 = miss_cnt;
    vid_addr = 14'h0300; vid_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 14'h0010; cpu_req = 1'b1;
    exp_vid.push_back(exp_mem(14'h0300));
    exp_cpu.push_back(exp_mem(14'h0010));
    step();
    vid_req = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 14'h0300}) begin
      errors++; $display("FAIL cont_vid_first: got %h want %h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 14'h0300});
    end
    step();
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 14'h0010}) begin
      errors++; $display("FAIL cont_cpu_next: got %h want %h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 14'h0010});
    end
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (cpu_ack === 1'b1) begin lat = i; break; end
    end
    cpu_req = 1'b0;
    step();
    step();
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL cont_ack_lat: got %0d want 2", lat);
    end
    checks++;
    if (obs_vid.size() == 0 || exp_vid.size() == 0) begin
      errors++; $display("FAIL cont_vid_data: got %0d entries want 1", obs_vid.size());
    end else begin
      got = obs_vid.pop_front(); want = exp_vid.pop_front();
      if (got !== want) begin
        errors++; $display("FAIL cont_vid_data: got %h want %h", got, want);
      end
    end
    checks++;
    if (obs_ack.size() == 0 || exp_cpu.size() == 0) begin
      errors++; $display("FAIL cont_cpu_data: got %0d entries want 1", obs_ack.size());
    end else begin
      got = obs_ack.pop_front(); want = exp_cpu.pop_front();
      if (got !== want) begin
        errors++; $display("FAIL cont_cpu_data: got %h want %h", got, want);
      end
    end
    checks++;
    if (miss_cnt != miss0) begin
      errors++; $display("FAIL cont_no_miss: got %0d misses want 0", miss_cnt - miss0);
    end
  endtask

  task automatic test_starvation;
    int miss0;
    int ack_k;
    logic [13:0] a;
    miss0 = miss_cnt;
    ack_k = -1;
    cpu_we = 1'b0; cpu_addr = 14'h0020; cpu_req = 1'b1;
    exp_cpu.push_back(exp_mem(14'h0020));
    for (int k = 0; k < 8; k++) begin
      a = 14'h0400 + 14'(k);
      vid_addr = a; vid_req = 1'b1;
      if (k != 5) exp_vid.push_back(exp_mem(a));
      step();
      checks++;
      if (k == 5) begin
        if ({vid_miss, mem_addr} !== {1'b1, 14'h0020}) begin
          errors++; $display("FAIL starve_grant k=%0d: got %h want %h", k, {vid_miss, mem_addr}, {1'b1, 14'h0020});
        end
      end else if ({vid_miss, mem_addr} !== {1'b0, a}) begin
        errors++; $display("FAIL starve_vid k=%0d: got %h want %h", k, {vid_miss, mem_addr}, {1'b0, a});
      end
      if (cpu_ack === 1'b1 && ack_k < 0) begin
        ack_k = k;
        cpu_req = 1'b0;
      end
    end
    vid_req = 1'b0;
    for (int i = 0; i < 10 && ack_k < 0; i++) begin
      step();
      if (cpu_ack === 1'b1) ack_k = 8 + i;
    end
    cpu_req = 1'b0;
    repeat (4) step();
    checks++;
    if (ack_k != 7) begin
      errors++; $display("FAIL starve_ack_at: got %0d want 7", ack_k);
    end
    checks++;
    if (miss_cnt - miss0 != 1) begin
      errors++; $display("FAIL starve_miss_cnt: got %0d want 1", miss_cnt - miss0);
    end
    checks++;
    if (obs_vid.size() != 7) begin
      errors++; $display("FAIL starve_vid_count: got %0d want 7", obs_vid.size());
    end
    while (obs_vid.size() > 0 && exp_vid.size() > 0) begin
      got = obs_vid.pop_front(); want = exp_vid.pop_front();
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL starve_vid_data: got %h want %h", got, want);
      end
    end
    obs_vid.delete(); exp_vid.delete();
    checks++;
    if (obs_ack.size() == 0 || exp_cpu.size() == 0) begin
      errors++; $display("FAIL starve_cpu_data: got %0d entries want 1", obs_ack.size());
    end else begin
      got = obs_ack.pop_front(); want = exp_cpu.pop_front();
      if (got !== want) begin
        errors++; $display("FAIL starve_cpu_data: got %h want %h", got, want);
      end
    end
  endtask

  task automatic test_held_req;
    int lat;
    logic wok;
    logic bad;
    cpu_we = 1'b0; cpu_addr = 14'h0030; cpu_req = 1'b1;
    exp_cpu.push_back(exp_mem(14'h0030));
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (cpu_ack === 1'b1) begin lat = i; break; end
    end
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL held_first_lat: got %0d want 4", lat);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cpu_wait !== 1'b0 || mem_en !== 1'b0 || cpu_ack !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL held_no_second: got activity %b want 0", bad);
    end
    checks++;
    if (obs_ack.size() == 0 || exp_cpu.size() == 0) begin
      errors++; $display("FAIL held_data: got %0d entries want 1", obs_ack.size());
    end else begin
      got = obs_ack.pop_front(); want = exp_cpu.pop_front();
      if (got !== want) begin
        errors++; $display("FAIL held_data: got %h want %h", got, want);
      end
    end
    cpu_req = 1'b0;
    step();
    exp_cpu.push_back(exp_mem(14'h0031));
    cpu_cycle(1'b0, 14'h0031, 8'h00, lat, wok);
    checks++;
    if (lat != 4 || wok !== 1'b1) begin
      errors++; $display("FAIL held_reraise: got lat %0d wait_ok %b want 4 1", lat, wok);
    end
    checks++;
    if (obs_ack.size() == 0 || exp_cpu.size() == 0) begin
      errors++; $display("FAIL held_reraise_data: got %0d entries want 1", obs_ack.size());
    end else begin
      got = obs_ack.pop_front(); want = exp_cpu.pop_front();
      if (got !== want) begin
        errors++; $display("FAIL held_reraise_data: got %h want %h", got, want);
      end
    end
  endtask

  task automatic test_final;
    repeat (4) step();
    checks++;
    if (obs_vid.size() + obs_ack.size() + exp_vid.size() + exp_cpu.size() != 0) begin
      errors++; $display("FAIL final_drain: got %0d/%0d/%0d/%0d leftover want 0",
                         obs_vid.size(), obs_ack.size(), exp_vid.size(), exp_cpu.size());
    end
  endtask

  initial begin
    test_reset();
    test_vid_fetch();
    test_cpu_write_read();
    test_contention();
    test_starvation();
    test_held_req();
    test_final();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
